// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RISC-V load/store size codes,
// arbiter state encoding and an access-size helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  // Illegal codes map to one byte; they are flagged separately as errors.
  function automatic logic [2:0] access_bytes(input logic [2:0] func3);
    case (func3)
      F3_H, F3_HU: access_bytes = 3'd2;
      F3_W:        access_bytes = 3'd4;
      default:     access_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bus of the data-memory arbiter; port i of
// every two-element field belongs to requester i.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [1:0]                 rq_valid;
  logic [1:0]                 rq_ready;
  logic [1:0]                 rq_we;
  logic [1:0][2:0]            rq_func3;
  logic [1:0][ADDR_WIDTH-1:0] rq_addr;
  logic [1:0][DATA_WIDTH-1:0] rq_wdata;
  logic [1:0]                 rs_valid;
  logic [1:0]                 rs_ready;
  logic [DATA_WIDTH-1:0]      rs_rdata;
  logic                       rs_err;

  // Requesters drive requests and accept responses.
  modport master (
    output rq_valid, rq_we, rq_func3, rq_addr, rq_wdata, rs_ready,
    input  rq_ready, rs_valid, rs_rdata, rs_err
  );

  // The arbiter accepts requests and drives responses.
  modport slave (
    input  rq_valid, rq_we, rq_func3, rq_addr, rq_wdata, rs_ready,
    output rq_ready, rs_valid, rs_rdata, rs_err
  );

endinterface

// File: rtl/dmem_req_check.sv
// Combinational legality check of a latched request: func3 code, natural
// alignment and fit of the whole access inside the implemented memory.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 32'h20000
) (
  input  logic                  we_i,
  input  logic [2:0]            func3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0] MemLimit = (ADDR_WIDTH+1)'(MEM_BYTES);

  logic                func3_err;
  logic                align_err;
  logic                range_err;
  logic [ADDR_WIDTH:0] last_byte;

  always_comb begin
    func3_err = 1'b0;
    if (we_i) begin
      func3_err = !(func3_i inside {F3_B, F3_H, F3_W});
    end else begin
      func3_err = !(func3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
  end

  always_comb begin
    align_err = 1'b0;
    case (func3_i)
      F3_H, F3_HU: align_err = addr_i[0];
      F3_W:        align_err = |addr_i[1:0];
      default:     align_err = 1'b0;
    endcase
  end

  // One extra bit so an access near the top of the address space cannot wrap.
  always_comb begin
    last_byte = {1'b0, addr_i} + (ADDR_WIDTH+1)'(access_bytes(func3_i))
                - (ADDR_WIDTH+1)'(1);
    range_err = (last_byte >= MemLimit);
  end

  assign err_o = func3_err | align_err | range_err;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between the CPU LSU (port 0) and
// the debug/DMA loader (port 1): one checked access per grant, registered response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 32'h20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         bus,
  output logic                  mem_write_enable,
  output logic [2:0]            mem_func3,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  arb_state_t state_q, state_d;

  logic                  rr_last_q;
  logic                  owner_q;
  logic                  we_q;
  logic [2:0]            func3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rs_rdata_q;
  logic                  rs_err_q;

  logic [1:0] grant;
  logic       winner;
  logic       req_fire;
  logic       err;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    grant  = 2'b00;
    winner = 1'b0;
    case (bus.rq_valid)
      2'b01: begin
        grant  = 2'b01;
        winner = 1'b0;
      end
      2'b10: begin
        grant  = 2'b10;
        winner = 1'b1;
      end
      2'b11: begin
        winner = ~rr_last_q;
        grant  = rr_last_q ? 2'b01 : 2'b10;
      end
      default: begin
        grant  = 2'b00;
        winner = 1'b0;
      end
    endcase
  end

  assign bus.rq_ready = (state_q == IDLE) ? grant : 2'b00;
  assign req_fire     = |(bus.rq_ready & bus.rq_valid);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.rs_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      func3_q   <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (state_q == IDLE && req_fire) begin
      rr_last_q <= winner;
      owner_q   <= winner;
      we_q      <= bus.rq_we[winner];
      func3_q   <= bus.rq_func3[winner];
      addr_q    <= bus.rq_addr[winner];
      wdata_q   <= bus.rq_wdata[winner];
    end
  end

  dmem_req_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_req_check (
    .we_i    (we_q),
    .func3_i (func3_q),
    .addr_i  (addr_q),
    .err_o   (err)
  );

  // Memory address/size follow the request latches, which only change on a
  // grant, so they hold their last value outside ACCESS.
  assign mem_address      = addr_q;
  assign mem_func3        = func3_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = (state_q == ACCESS) & we_q & ~err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_rdata_q <= '0;
      rs_err_q   <= 1'b0;
    end else if (state_q == ACCESS) begin
      rs_err_q   <= err;
      rs_rdata_q <= (!we_q && !err) ? mem_data_out : '0;
    end
  end

  assign bus.rs_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rs_rdata = rs_rdata_q;
  assign bus.rs_err   = rs_err_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.rq_ready));

  write_in_access_a: assert property (@(posedge clk) disable iff (!rst_n)
    mem_write_enable |-> (state_q == ACCESS));

  access_one_cycle_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACCESS) |=> (state_q == RESP));

  resp_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RESP && !bus.rs_ready[owner_q]) |=>
      (state_q == RESP && $stable(rs_rdata_q) && $stable(rs_err_q)));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array memory model, reference
// memory and a response scoreboard filled at each request handshake.
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 32'h20000;

  logic        clk;
  logic        rst_n;
  logic        mem_write_enable;
  logic [2:0]  mem_func3;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_data_out;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_BYTES  (MEM_BYTES)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .mem_write_enable (mem_write_enable),
    .mem_func3        (mem_func3),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_data_out     (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int we_cycles = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data memory seen by the DUT.
  logic [7:0] mem [0:MEM_BYTES-1];
  // Reference contents, updated when a response is accepted.
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_write_enable) begin
      we_cycles <= we_cycles + 1;
      mem[mem_address[16:0]] <= mem_write_data[7:0];
      if (mem_func3 != 3'd0) mem[mem_address[16:0] + 17'd1] <= mem_write_data[15:8];
      if (mem_func3 == 3'd2) begin
        mem[mem_address[16:0] + 17'd2] <= mem_write_data[23:16];
        mem[mem_address[16:0] + 17'd3] <= mem_write_data[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = (mem_address < MEM_BYTES) ? mem[mem_address[16:0]] : 8'h0;
    b1 = (mem_address + 1 < MEM_BYTES) ? mem[mem_address[16:0] + 17'd1] : 8'h0;
    b2 = (mem_address + 2 < MEM_BYTES) ? mem[mem_address[16:0] + 17'd2] : 8'h0;
    b3 = (mem_address + 3 < MEM_BYTES) ? mem[mem_address[16:0] + 17'd3] : 8'h0;
    case (mem_func3)
      3'd0:    mem_data_out = {{24{b0[7]}}, b0};
      3'd1:    mem_data_out = {{16{b1[7]}}, b1, b0};
      3'd2:    mem_data_out = {b3, b2, b1, b0};
      3'd4:    mem_data_out = {24'h0, b0};
      3'd5:    mem_data_out = {16'h0, b1, b0};
      default: mem_data_out = 32'h0;
    endcase
  end

  function automatic int unsigned ref_size(input logic [2:0] f3);
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    if (f3 == 3'd2) return 4;
    return 1;
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    logic bad;
    sz  = ref_size(f3);
    bad = we ? !(f3 <= 3'd2) : !(f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((a % sz) != 0) bad = 1'b1;
    if (64'(a) + 64'(sz) > 64'(MEM_BYTES)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] ref_read(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < int'(ref_size(f3)); i++) w[8*i +: 8] = ref_mem[a[16:0] + 17'(i)];
    if (f3 == 3'd0) w = {{24{w[7]}}, w[7:0]};
    if (f3 == 3'd1) w = {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hs_cyc;
  } exp_t;

  exp_t        sb [$];
  int          grant_log [$];
  exp_t        e;
  logic        resp_seen = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;

  // Scoreboard: push on request handshake, compare while valid, pop on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (bus.rq_valid[p] && bus.rq_ready[p]) begin
          e.port   = p;
          e.we     = bus.rq_we[p];
          e.f3     = bus.rq_func3[p];
          e.addr   = bus.rq_addr[p];
          e.wdata  = bus.rq_wdata[p];
          e.err    = ref_err(e.we, e.f3, e.addr);
          e.rdata  = (e.we || e.err) ? 32'h0 : ref_read(e.f3, e.addr);
          e.hs_cyc = cycle;
          sb.push_back(e);
          grant_log.push_back(p);
        end
      end
      if (|bus.rs_valid) begin
        if (sb.size() == 0) begin
          chk("rs_unexpected", bus.rs_valid, 2'b00);
        end else begin
          e = sb[0];
          chk("rs_port", bus.rs_valid, (e.port == 1) ? 2'b10 : 2'b01);
          if (!resp_seen) chk("latency", cycle - e.hs_cyc, 2);
          resp_seen = 1'b1;
          chk("rs_rdata", bus.rs_rdata, e.rdata);
          chk("rs_err", bus.rs_err, e.err);
          if (|(bus.rs_valid & bus.rs_ready)) begin
            void'(sb.pop_front());
            resp_seen  = 1'b0;
            last_rdata = bus.rs_rdata;
            last_err   = bus.rs_err;
            if (e.we && !e.err) begin
              for (int i = 0; i < int'(ref_size(e.f3)); i++)
                ref_mem[e.addr[16:0] + 17'(i)] = e.wdata[8*i +: 8];
            end
          end
        end
      end
    end
  end

  task automatic send(input int p, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    bus.rq_we[p]    = we;
    bus.rq_func3[p] = f3;
    bus.rq_addr[p]  = a;
    bus.rq_wdata[p] = wd;
    bus.rq_valid[p] = 1'b1;
    #1;
    while (!bus.rq_ready[p] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("grant", bus.rq_ready[p], 1'b1);
    @(posedge clk); #1;
    bus.rq_valid[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.rs_valid != 2'b00) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rq_ready"}, bus.rq_ready, 2'b00);
    chk({tag, "_rs_valid"}, bus.rs_valid, 2'b00);
    chk({tag, "_rs_rdata"}, bus.rs_rdata, 32'h0);
    chk({tag, "_rs_err"}, bus.rs_err, 1'b0);
    chk({tag, "_mem_we"}, mem_write_enable, 1'b0);
    chk({tag, "_mem_f3"}, mem_func3, 3'd0);
    chk({tag, "_mem_addr"}, mem_address, 32'h0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'h0);
  endtask

  int w0;
  int n;

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      mem[i]     = 8'h0;
      ref_mem[i] = 8'h0;
    end
    rst_n        = 1'b0;
    bus.rq_valid = 2'b00;
    bus.rq_we    = 2'b00;
    bus.rq_func3 = '0;
    bus.rq_addr  = '0;
    bus.rq_wdata = '0;
    bus.rs_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // Both ports loading and held from reset: strict alternation starting at port 0.
    bus.rq_func3[0] = 3'd2; bus.rq_addr[0] = 32'h10;
    bus.rq_func3[1] = 3'd2; bus.rq_addr[1] = 32'h20;
    bus.rq_valid    = 2'b11;
    rst_n           = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    bus.rq_valid = 2'b00;
    wait_idle();
    chk("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk($sformatf("rr_order%0d", i), grant_log[i], i % 2);
    end

    // Word store then load back.
    w0 = we_cycles;
    send(0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
    wait_idle();
    chk("sw_we_pulse", we_cycles - w0, 1);
    chk("sw_err", last_err, 1'b0);
    send(0, 1'b0, 3'd2, 32'h100, 32'h0);
    wait_idle();
    chk("lw_data", last_rdata, 32'hDEAD_BEEF);
    chk("lw_err", last_err, 1'b0);

    // Misaligned half store is rejected without touching memory.
    w0 = we_cycles;
    send(1, 1'b1, 3'd1, 32'h101, 32'h0000_CAFE);
    wait_idle();
    chk("sh_mis_err", last_err, 1'b1);
    chk("sh_mis_no_we", we_cycles - w0, 0);
    send(0, 1'b0, 3'd2, 32'h100, 32'h0);
    wait_idle();
    chk("mem_unchanged", last_rdata, 32'hDEAD_BEEF);

    // Range boundary.
    send(1, 1'b0, 3'd0, 32'h1FFFF, 32'h0);
    wait_idle();
    chk("lb_top_err", last_err, 1'b0);
    send(1, 1'b0, 3'd2, 32'h1FFFE, 32'h0);
    wait_idle();
    chk("lw_over_err", last_err, 1'b1);
    chk("lw_over_data", last_rdata, 32'h0);

    // Illegal func3 on a load.
    send(0, 1'b0, 3'd3, 32'h100, 32'h0);
    wait_idle();
    chk("f3_bad_err", last_err, 1'b1);

    // Byte sign/zero extension.
    send(0, 1'b1, 3'd0, 32'h40, 32'h0000_0080);
    wait_idle();
    send(1, 1'b0, 3'd0, 32'h40, 32'h0);
    wait_idle();
    chk("lb_sext", last_rdata, 32'hFFFF_FF80);
    send(1, 1'b0, 3'd4, 32'h40, 32'h0);
    wait_idle();
    chk("lbu_zext", last_rdata, 32'h0000_0080);

    // Response backpressure while the other port waits.
    bus.rs_ready[0] = 1'b0;
    send(0, 1'b0, 3'd2, 32'h100, 32'h0);
    bus.rq_we[1] = 1'b0; bus.rq_func3[1] = 3'd2; bus.rq_addr[1] = 32'h40;
    bus.rq_valid[1] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus.rs_valid, 2'b01);
      chk("stall_rdata", bus.rs_rdata, 32'hDEAD_BEEF);
      chk("stall_err", bus.rs_err, 1'b0);
      chk("stall_no_grant", bus.rq_ready, 2'b00);
      @(posedge clk); #1;
    end
    bus.rs_ready[0] = 1'b1;
    chk("accept_no_grant", bus.rq_ready, 2'b00);
    @(posedge clk); #1;
    chk("p1_grant_after", bus.rq_ready, 2'b10);
    @(posedge clk); #1;
    bus.rq_valid[1] = 1'b0;
    wait_idle();
    chk("p1_lw_data", last_rdata, 32'h0000_0080);

    // Reset during the ACCESS cycle of a store.
    send(0, 1'b1, 3'd2, 32'h200, 32'h1234_5678);
    w0 = we_cycles;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    resp_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rs", bus.rs_valid, 2'b00);
    end
    chk("abandoned_no_we", we_cycles - w0, 0);
    bus.rq_we    = 2'b00;
    bus.rq_func3[0] = 3'd2; bus.rq_addr[0] = 32'h200;
    bus.rq_func3[1] = 3'd2; bus.rq_addr[1] = 32'h204;
    bus.rq_valid = 2'b11;
    #1;
    chk("post_rst_p0_first", bus.rq_ready, 2'b01);
    @(posedge clk); #1;
    bus.rq_valid[0] = 1'b0;
    n = 0;
    while (!bus.rq_ready[1] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("post_rst_p1", bus.rq_ready, 2'b10);
    @(posedge clk); #1;
    bus.rq_valid[1] = 1'b0;
    wait_idle();
    send(0, 1'b0, 3'd2, 32'h200, 32'h0);
    wait_idle();
    chk("abandoned_mem", last_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters.
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Performs round-robin arbitration, validates alignment, func3 and address range, then sequences one memory access per grant and returns a registered response with backpressure.
- Sits between the requesters and data_memory, driving its write_enable, func3, address and write_data inputs and sampling its data_out.

Parameters:
ADDR_WIDTH, 32, requester and memory address width
DATA_WIDTH, 32, data width
MEM_BYTES, 32'h20000, implemented memory size in bytes; legal addresses are 0..MEM_BYTES-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rq_valid  in  2  per-port request valid; bit i = port i
rq_ready  out  2  per-port request accepted this cycle
rq_we  in  2  per-port write flag
rq_func3  in  2x3  per-port access size/sign (RISC-V load/store func3)
rq_addr  in  2xADDR_WIDTH  per-port byte address
rq_wdata  in  2xDATA_WIDTH  per-port store data
rs_valid  out  2  per-port response valid
rs_ready  in  2  per-port response accepted
rs_rdata  out  DATA_WIDTH  response load data (shared bus, qualified by rs_valid)
rs_err  out  1  response error flag (shared, qualified by rs_valid)
mem_write_enable  out  1  to data memory
mem_func3  out  3  to data memory
mem_address  out  ADDR_WIDTH  to data memory
mem_write_data  out  DATA_WIDTH  to data memory
mem_data_out  in  DATA_WIDTH  combinational read data from data memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: async on rst_n low.
  - State goes to IDLE; rr_last=1, so port 0 wins the first tie.
  - rq_ready=0, rs_valid=0, rs_rdata=0, rs_err=0, mem_write_enable=0, mem_func3=0, mem_address=0, mem_write_data=0.
  - Reset mid-access abandons the transaction; no response is issued.
- IDLE arbitration (combinational):
  - Winner is the only valid port.
  - If both ports are valid, winner is the port != rr_last.
  - rq_ready is asserted only to the winner, and only in IDLE.
  - On handshake, latch owner, we, func3, addr and wdata; set rr_last=owner; go to ACCESS.
- Checks on latched request → err:
  - Write with func3 not in {0,1,2}.
  - Read with func3 not in {0,1,2,4,5}.
  - Half access (func3 1/5) with addr[0]!=0.
  - Word access (func3 2) with addr[1:0]!=0.
  - Any addr+size-1 > MEM_BYTES-1.
- ACCESS (exactly 1 cycle):
  - mem_address, mem_func3 and mem_write_data are driven from the latches.
  - mem_write_enable = we & ~err.
  - On a read without err, capture mem_data_out into rs_rdata; otherwise rs_rdata=0.
  - Capture rs_err=err; go to RESP.
- Outside ACCESS: mem_write_enable=0; mem_address and mem_func3 hold their last values.
- RESP:
  - rs_valid[owner]=1 until rs_ready[owner]; rs_rdata and rs_err are stable meanwhile.
  - On accept, go to IDLE.
  - A new request cannot be accepted in the same cycle as the accept.
- Latency: request handshake at cycle N → rs_valid at N+2 (registered). Peak throughput is one access per 3 cycles.
- Writes complete in ACCESS, so write data is visible to any subsequent grant.
- Requests held valid while not granted must stay stable; the arbiter never drops them.

Decomposition:
- Shared package dmem_pkg holds:
  - func3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum typedef arb_state_t {IDLE, ACCESS, RESP}.
  - Function access_bytes(func3) returning 1, 2 or 4.
- One natural sub-module, dmem_req_check: combinational check of we, func3 and addr against MEM_BYTES, returning err.

Test Plan:
- Port 0 SW addr=0x100 wdata=0xDEADBEEF, then port 0 LW 0x100 → mem_write_enable high exactly 1 cycle; rs_valid at N+2 both times; rs_rdata=0xDEADBEEF, rs_err=0.
- Both ports valid from reset with LW to 0x10 (port 0) and 0x20 (port 1), held → grants in order port0, port1, port0, port1; no starvation.
- Port 1 SH addr=0x101 → rs_err=1, mem_write_enable never asserted, memory unchanged. Port 1 LB addr=0x1FFFF → err=0. LW addr=0x1FFFE → err=1.
- Store byte 0x80 at 0x40, then LB 0x40 → 0xFFFFFF80; LBU 0x40 → 0x00000080.
- rs_ready held low for 5 cycles → rs_valid, rs_rdata and rs_err stable; the other port's valid request is not granted until the accept.
- rst_n pulsed low during ACCESS of a SW → outputs at reset values immediately, no rs_valid; next request after reset is granted to port 0 first.
